fifo_ptr_ctrl: RTL

- Single-clock FIFO controller that sequences a dual-port RAM.
- Owns the write and read pointers, accepts or rejects push/pop requests, drives the RAM write/read strobes and addresses, and maintains the full/empty/count status.
- Exports Gray-coded pointers (ADDR_W+1 bits) for downstream status and crossing logic.
- Sits between the FIFO top and the storage array.

---
 rtl/fifo_ptr_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: single-clock FIFO pointer/status controller for a
// synchronous-read dual-port RAM. It owns the binary write/read pointers,
// accepts or rejects pushes and pops, and keeps count/full/empty plus the
// Gray-coded pointers up to date.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds registered
// almost_full/almost_empty flags driven by AF_LEVEL/AE_LEVEL.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_next;
  logic [PTR_W-1:0] rptr_next;
  logic [PTR_W-1:0] count_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rgray_next;
  logic             full_next;
  logic             empty_next;
  logic             push_ok;
  logic             pop_ok;

  // RAM strobes and addresses come straight from the registered flags/pointers
  assign push_ok   = wr_en & ~full;
  assign pop_ok    = rd_en & ~empty;
  assign mem_we    = push_ok;
  assign mem_re    = pop_ok;
  assign mem_waddr = wptr[ADDR_W-1:0];
  assign mem_raddr = rptr[ADDR_W-1:0];

  // Next-state pointers, occupancy, flags and Gray codes
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    count_next = count;
    if (push_ok) begin
      wptr_next = wptr + PTR_W'(1);
    end
    if (pop_ok) begin
      rptr_next = rptr + PTR_W'(1);
    end
    count_next = count + PTR_W'(push_ok) - PTR_W'(pop_ok);
    full_next  = (count_next == PTR_W'(DEPTH));
    empty_next = (count_next == '0);
    wgray_next = wptr_next ^ (wptr_next >> 1);
    rgray_next = rptr_next ^ (rptr_next >> 1);
  end

  // State register; rejected requests only raise the error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      wptr_gray <= '0;
      rptr_gray <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      count     <= count_next;
      full      <= full_next;
      empty     <= empty_next;
      wptr_gray <= wgray_next;
      rptr_gray <= rgray_next;
      rd_valid  <= pop_ok;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AE_LEVEL);

  // Threshold flags track the next-state occupancy like full/empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_TH);
      almost_empty <= (count_next <= AE_TH);
    end
  end
`else
  // Thresholds have no function without the almost flags
  logic unused_levels;
  assign unused_levels = ^{AF_LEVEL, AE_LEVEL};
`endif

endmodule
